// File: rtl/apb2_pwm_timer.sv
// APB2 slave with NCH edge-aligned PWM channels sharing one prescaler and period counter.
// Optional output polarity register is enabled by defining PWM_POLARITY_EN.
module apb2_pwm_timer #(
   parameter int unsigned NCH = 4,
   parameter int unsigned CW  = 16
) (
   input  logic           pclk,
   input  logic           presetn,
   input  logic           psel,
   input  logic           penable,
   input  logic           pwrite,
   input  logic [7:0]     paddr,
   input  logic [31:0]    pwdata,
   output logic [31:0]    prdata,
   output logic           pready,
   output logic [NCH-1:0] pwm_out,
   output logic           irq
);

   localparam logic [5:0] ADDR_CTRL   = 6'h00;
   localparam logic [5:0] ADDR_PRESC  = 6'h01;
   localparam logic [5:0] ADDR_PERIOD = 6'h02;
   localparam logic [5:0] ADDR_STATUS = 6'h03;
   localparam logic [5:0] ADDR_POL    = 6'h04;
   localparam logic [5:0] ADDR_DUTY   = 6'h08;

   logic [5:0]     widx;
   logic           wr;
   logic           wr_ctrl, wr_presc, wr_period, wr_status;
   logic [NCH-1:0] wr_duty;

   logic           en, irqen, wrap;
   logic [15:0]    presc, pcnt;
   logic [CW-1:0]  period, per_sh, cnt;
   logic [CW-1:0]  duty    [NCH];
   logic [CW-1:0]  duty_sh [NCH];
   logic [NCH-1:0] raw;
   logic [31:0]    rdata;

   logic           en_nxt, en_rise, tick, wrap_hit;

   logic           unused_bits;

`ifdef PWM_POLARITY_EN
   logic           wr_pol;
   logic [NCH-1:0] pol;
   assign wr_pol = wr & (widx == ADDR_POL);
`endif

   assign unused_bits = ^{paddr[1:0], pwdata[31:16]};

   assign widx      = paddr[7:2];
   assign wr        = psel & penable & pwrite;
   assign wr_ctrl   = wr & (widx == ADDR_CTRL);
   assign wr_presc  = wr & (widx == ADDR_PRESC);
   assign wr_period = wr & (widx == ADDR_PERIOD);
   assign wr_status = wr & (widx == ADDR_STATUS);

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         wr_duty[i] = wr & (widx == ADDR_DUTY + 6'(i));
      end
   end

   assign en_nxt   = wr_ctrl ? pwdata[0] : en;
   assign en_rise  = en_nxt & ~en;
   assign tick     = en & (pcnt == presc);
   assign wrap_hit = tick & (cnt == per_sh);

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         raw[i] = en & (cnt < duty_sh[i]);
      end
   end

   // Configuration registers and W1C status.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         en     <= 1'b0;
         irqen  <= 1'b0;
         presc  <= '0;
         period <= '0;
         wrap   <= 1'b0;
         for (int i = 0; i < NCH; i++) duty[i] <= '0;
`ifdef PWM_POLARITY_EN
         pol    <= '0;
`endif
      end else begin
         if (wr_ctrl) begin
            en    <= pwdata[0];
            irqen <= pwdata[1];
         end
         if (wr_presc)  presc  <= pwdata[15:0];
         if (wr_period) period <= pwdata[CW-1:0];
         for (int i = 0; i < NCH; i++) begin
            if (wr_duty[i]) duty[i] <= pwdata[CW-1:0];
         end
`ifdef PWM_POLARITY_EN
         if (wr_pol) pol <= pwdata[NCH-1:0];
`endif
         // A wrap on the same edge as a clear keeps the flag set.
         if (wrap_hit) wrap <= 1'b1;
         else if (wr_status && pwdata[0]) wrap <= 1'b0;
      end
   end

   // Prescaler, main counter and shadow registers.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         pcnt   <= '0;
         cnt    <= '0;
         per_sh <= '0;
         for (int i = 0; i < NCH; i++) duty_sh[i] <= '0;
      end else if (!en_nxt) begin
         pcnt <= '0;
         cnt  <= '0;
      end else if (en_rise) begin
         pcnt   <= '0;
         cnt    <= '0;
         per_sh <= period;
         for (int i = 0; i < NCH; i++) duty_sh[i] <= duty[i];
      end else if (tick) begin
         pcnt <= '0;
         if (cnt == per_sh) begin
            cnt    <= '0;
            per_sh <= period;
            for (int i = 0; i < NCH; i++) duty_sh[i] <= duty[i];
         end else begin
            cnt <= cnt + CW'(1);
         end
      end else begin
         pcnt <= pcnt + 16'd1;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         pwm_out <= '0;
         irq     <= 1'b0;
      end else begin
`ifdef PWM_POLARITY_EN
         pwm_out <= raw ^ pol;
`else
         pwm_out <= raw;
`endif
         irq     <= wrap & irqen;
      end
   end

   always_comb begin
      rdata = '0;
      case (widx)
         ADDR_CTRL:   rdata[1:0]    = {irqen, en};
         ADDR_PRESC:  rdata[15:0]   = presc;
         ADDR_PERIOD: rdata[CW-1:0] = period;
         ADDR_STATUS: rdata[0]      = wrap;
`ifdef PWM_POLARITY_EN
         ADDR_POL:    rdata[NCH-1:0] = pol;
`endif
         default:     ;
      endcase
      for (int i = 0; i < NCH; i++) begin
         if (widx == ADDR_DUTY + 6'(i)) rdata[CW-1:0] = duty[i];
      end
   end

   assign prdata = psel ? rdata : 32'd0;
   assign pready = 1'b1;

endmodule

// File: doc/apb2_pwm_timer.md
Name: apb2_pwm_timer

Overview:
- APB2 slave peripheral on the EMPU APB2 Master [1] port, placed downstream of the APB2 address decoder.
- It takes the decoded psel/penable and the master's pwrite/paddr/pwdata, and returns prdata/pready to the master.
- It generates NCH edge-aligned PWM outputs from one shared prescaler and period counter, with double-buffered period/duty and a period-wrap interrupt.

Parameters:
- NCH, 4, number of PWM channels (1..8).
- CW, 16, width of the counter, period and duty registers (8..16).

Ports:
- pclk  in  1  APB/peripheral clock (the EMPU master_pclk).
- presetn  in  1  asynchronous active-low reset.
- psel  in  1  decoded slave select.
- penable  in  1  decoded access-phase enable.
- pwrite  in  1  1 = write.
- paddr  in  8  byte address; only paddr[7:2] is decoded.
- pwdata  in  32  write data.
- prdata  out  32  read data.
- pready  out  1  transfer ready.
- pwm_out  out  NCH  PWM outputs.
- irq  out  1  wrap interrupt, level.

Behaviour:
- Register map (word offsets):
  - 0x00 CTRL: [0] EN, [1] IRQEN.
  - 0x04 PRESC: [15:0].
  - 0x08 PERIOD: [CW-1:0].
  - 0x0C STATUS: [0] WRAP, write-1-to-clear.
  - 0x10 POL: [NCH-1:0] (see optional feature).
  - 0x20+4*i DUTY[i]: [CW-1:0].
  - Unmapped offsets read 0; writes to them are ignored. Unused register bits read 0.
- APB2 protocol, zero wait:
  - pready is tied to 1.
  - A write commits on the pclk edge where psel & penable & pwrite.
  - prdata is combinational from paddr while psel=1, and 0 when psel=0.
  - Reads have no side effects.
- Reset values: all registers 0, shadow registers 0, prescaler count 0, main count 0, pwm_out 0, irq 0.
- Prescaler:
  - pcnt counts 0..PRESC; tick = EN & (pcnt==PRESC).
  - On tick, pcnt returns to 0.
  - PRESC=0 gives a tick every cycle.
- Main counter cnt (CW bits), on tick:
  - If cnt==per_sh: cnt<=0, per_sh<=PERIOD, duty_sh[i]<=DUTY[i], STATUS.WRAP<=1.
  - Otherwise cnt<=cnt+1.
  - One PWM period is (PERIOD+1)*(PRESC+1) pclk cycles.
- Enable edge:
  - A write taking EN from 0 to 1 loads per_sh/duty_sh from the live registers on the same edge and zeroes pcnt and cnt.
  - While EN=0, pcnt and cnt are held at 0, and no ticks or wraps occur.
- Compare output:
  - raw[i] = EN & (cnt < duty_sh[i]), registered into pwm_out, so outputs have 1 cycle of latency from cnt.
  - DUTY=0 gives constant low; DUTY>PERIOD gives constant high while enabled.
- PERIOD=0: cnt stays 0, a wrap occurs every tick, and raw[i] = (duty_sh[i]!=0).
- Live PERIOD/DUTY writes while running take effect only at the next wrap, never mid-period.
- irq = STATUS.WRAP & CTRL.IRQEN, registered (1 cycle after the flag or enable changes).
- STATUS.WRAP clear vs set: if a W1C write to WRAP and a wrap fall on the same edge, the set wins (WRAP stays 1).
- Clearing EN mid-period:
  - The counters reset to 0 on that edge; pwm_out goes low on the following edge.
  - WRAP keeps its value.
- Asynchronous reset assertion mid-operation forces every register and output to its reset value immediately.

Optional Feature:
- Macro: PWM_POLARITY_EN.
- Defined:
  - POL at 0x10 is read/write.
  - pwm_out[i] = registered (raw[i] ^ POL[i]); while EN=0 an output idles at POL[i].
  - POL changes take effect immediately (not shadowed), after the 1-cycle output register.
- Undefined:
  - Offset 0x10 reads 0 and writes are ignored.
  - No POL flops exist; outputs are active-high and idle low.

Test Plan:
1. Reset then read all registers -> prdata=0 at 0x00..0x20+4*(NCH-1); pwm_out=0; irq=0; pready=1 throughout.
2. PRESC=0, PERIOD=9, DUTY0=3, DUTY1=0, DUTY2=10, EN=1 -> pwm_out[0] high 3 of every 10 cycles; pwm_out[1] always 0; pwm_out[2] always 1; a wrap every 10 cycles.
3. PRESC=1, PERIOD=3, DUTY0=2, running; write DUTY0=1 and PERIOD=7 mid-period -> the current 8-cycle period is unchanged; from the next wrap the period is 16 cycles with 2 cycles high.
4. IRQEN=1, EN=1, PERIOD=4 -> irq asserts 1 cycle after WRAP sets; W1C of STATUS=1 clears irq; a W1C issued on the same edge as a wrap leaves WRAP=1.
5. Write EN=0 mid-period, then EN=1 -> cnt restarts at 0 with fresh shadows; assert presetn=0 mid-run -> pwm_out and irq go 0 immediately.
6. With PWM_POLARITY_EN, POL=4'b0101, PERIOD=9, DUTY0=3 -> pwm_out[0] low 3 of every 10 cycles; idles high when EN=0. Without the macro, writing 0x10 then reading it back returns 0.
